// File: rtl/cpu_axi_bridge.sv
// Bridges the IF and MEM sram-like masters onto one AXI master port.
// Ports: clk/resetn, inst_sram_*, data_sram_*, AXI ar/r/aw/w/b. Option: AXI_BRIDGE_RBUF_EN.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST  = 4'd0,
  parameter logic [3:0] ID_DATA  = 4'd1,
  parameter logic [3:0] WID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_WAIT, R_BUF
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE, W_SEND, W_RESP
  } wstate_t;

  rstate_t     r_q;
  wstate_t     w_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;

  logic        rd_dcand;
  logic        rd_acc;
  logic        wr_acc;
  logic        r_hit;
  logic [3:0]  r_id;
  logic [31:0] r_data;

  assign rd_dcand = data_sram_req & ~data_sram_wr;

  // reads wait for an idle write path (conservative RAW guard)
  assign rd_acc = resetn & (r_q == R_IDLE) & (w_q == W_IDLE)
                & (rd_dcand | inst_sram_req);

  // a store may overlap only an outstanding fetch
  assign wr_acc = resetn & data_sram_req & data_sram_wr
                & (w_q == W_IDLE)
                & ((r_q == R_IDLE) | (arid_q == ID_INST));

  assign inst_sram_addr_ok = rd_acc & ~rd_dcand;
  assign data_sram_addr_ok = (rd_acc & rd_dcand) | wr_acc;

`ifdef AXI_BRIDGE_RBUF_EN
  logic [31:0] rbuf_q;
  logic [3:0]  rid_q;
  assign r_hit  = (r_q == R_BUF);
  assign r_id   = rid_q;
  assign r_data = rbuf_q;
`else
  assign r_hit  = (r_q == R_WAIT) & rvalid;
  assign r_id   = rid;
  assign r_data = rdata;
`endif

  assign inst_sram_data_ok = resetn & r_hit & (r_id == ID_INST);
  assign data_sram_data_ok = resetn
    & ((r_hit & (r_id == ID_DATA)) | ((w_q == W_RESP) & bvalid));
  assign inst_sram_rdata = r_data;
  assign data_sram_rdata = r_data;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = WID_DATA;
  assign wid     = WID_DATA;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q       <= R_IDLE;
      w_q       <= W_IDLE;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef AXI_BRIDGE_RBUF_EN
      rbuf_q    <= '0;
      rid_q     <= '0;
`endif
    end else begin
      unique case (r_q)
        R_IDLE: if (rd_acc) begin
          araddr_q  <= rd_dcand ? data_sram_addr : inst_sram_addr;
          arsize_q  <= rd_dcand ? {1'b0, data_sram_size} : 3'd2;
          arid_q    <= rd_dcand ? ID_DATA : ID_INST;
          arvalid_q <= 1'b1;
          r_q       <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          r_q       <= R_WAIT;
        end
        R_WAIT: if (rvalid) begin
          rready_q <= 1'b0;
`ifdef AXI_BRIDGE_RBUF_EN
          rbuf_q   <= rdata;
          rid_q    <= rid;
          r_q      <= R_BUF;
`else
          r_q      <= R_IDLE;
`endif
        end
        default: r_q <= R_IDLE;
      endcase

      unique case (w_q)
        W_IDLE: if (wr_acc) begin
          awaddr_q  <= data_sram_addr;
          awsize_q  <= {1'b0, data_sram_size};
          wdata_q   <= data_sram_wdata;
          wstrb_q   <= data_sram_wstrb;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          w_q       <= W_SEND;
        end
        W_SEND: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((~awvalid_q | awready) & (~wvalid_q | wready)) begin
            bready_q <= 1'b1;
            w_q      <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          bready_q <= 1'b0;
          w_q      <= W_IDLE;
        end
        default: w_q <= W_IDLE;
      endcase
    end
  end

endmodule
